// File: rtl/core_pkg.sv
// Shared definitions for the core's pipeline control blocks.
package core_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MD_LATENCY_DEF = 4;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, MUL/DIV EX occupancy and
// taken-branch flushes, plus a stall-cycle performance counter.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             ex_md_start,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    md_state_e  state, state_next;
    logic [3:0] md_cnt, md_cnt_next;
    logic       load_use;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = id_ex_memread && (id_ex_rd != REG_ZERO) &&
                      ((id_use_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == id_ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        md_cnt_next   = md_cnt;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        md_busy       = 1'b0;
        md_done       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ex_md_start) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    state_next    = ST_MD_BUSY;
                    md_cnt_next   = MD_LOAD;
                end else if (ex_branch_taken) begin
                    // The ID instruction is wrong-path: flush it rather than stall on it.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                md_busy     = 1'b1;
                md_cnt_next = md_cnt - 4'd1;
                if (md_cnt == 4'd1) begin
                    md_done    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Hold the whole pipeline inert while reset is asserted.
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b0;
            ex_mem_bubble = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            md_busy       = 1'b0;
            md_done       = 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (!pc_write),
        .count(stall_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core; works alongside the operand forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use stalls;
  - multi-cycle MUL/DIV occupancy of EX;
  - taken-branch flushes.
- Drives PC/IF-ID/ID-EX write enables, bubble insertion and flushes.
- Sequential core: a MUL/DIV busy FSM with a latency counter, plus a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 4, total EX cycles a MUL/DIV occupies (legal range 2..15).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_rs1  input  5  rs1 of the instruction in ID.
- id_rs2  input  5  rs2 of the instruction in ID.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_ex_rd  input  5  rd of the instruction in EX.
- id_ex_memread  input  1  EX instruction is a load.
- ex_md_start  input  1  EX instruction is MUL/DIV (level; held while EX is frozen).
- ex_branch_taken  input  1  branch/jump in EX resolved taken.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register enable.
- id_ex_write  output  1  ID/EX register enable.
- id_ex_bubble  output  1  zero the ID/EX control fields (insert NOP).
- ex_mem_bubble  output  1  zero the EX/MEM control fields.
- if_id_flush  output  1  clear IF/ID on the next edge.
- id_ex_flush  output  1  clear ID/EX on the next edge.
- md_busy  output  1  FSM in MD_BUSY.
- md_done  output  1  one-cycle pulse on the final MUL/DIV cycle.
- stall_cnt  output  CNT_W  cycles with pc_write=0, saturating.

Behaviour:
- FSM states are IDLE and MD_BUSY. A 4-bit down-counter md_cnt is used.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, md_cnt=0, stall_cnt=0.
  - While reset is asserted, all outputs are 0, including pc_write, if_id_write and id_ex_write.
  - Reset mid-MUL/DIV abandons the operation; no md_done is produced.
- Outputs are combinational from state, md_cnt and the inputs; there is no added latency.
- Default (IDLE, no hazard): pc_write, if_id_write and id_ex_write are 1; every other 1-bit output is 0.
- Load-use (IDLE only):
  - Condition: id_ex_memread=1, id_ex_rd!=0, and (id_use_rs1 with id_rs1==id_ex_rd, or id_use_rs2 with id_rs2==id_ex_rd).
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Exactly one stall cycle. The next cycle the load is in MEM and forwarding resolves the dependency.
- Taken branch (IDLE):
  - ex_branch_taken=1 gives if_id_flush=1 and id_ex_flush=1.
  - pc_write stays 1 so the branch target is loaded.
  - Branch has priority over load-use: the ID instruction is wrong-path, so no stall and no bubble.
- MUL/DIV:
  - In IDLE with ex_md_start=1: enter MD_BUSY with md_cnt=MD_LATENCY-1.
  - During that IDLE cycle: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
  - ex_md_start takes priority over load-use detection in the same cycle.
- MD_BUSY:
  - Each cycle md_cnt decrements.
  - While md_cnt!=1: keep the freeze (pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1).
  - When md_cnt==1: md_done=1, ex_mem_bubble=0, all writes=1 (result advances), next state IDLE.
  - ex_md_start and ex_branch_taken are ignored in MD_BUSY. The frozen EX cannot hold a branch.
  - Total occupancy is MD_LATENCY cycles, with md_done on the last one.
- Back-to-back MUL/DIV: a second MUL/DIV entering EX the cycle after md_done restarts from IDLE with no gap cycle.
- md_busy=1 exactly while state==MD_BUSY.
- stall_cnt:
  - Increments on every clock where rst_n=1 and pc_write=0.
  - Saturates at all-ones; no wrap.
- rd=x0 never causes a load-use stall.

Decomposition:
- Shared package core_pkg holds:
  - the FSM state encoding (ST_IDLE=1'b0, ST_MD_BUSY=1'b1);
  - REG_ZERO=5'd0;
  - the MD_LATENCY default.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output count).
- Hazard detection and the FSM stay in hazard_ctrl.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 for that cycle only; stall_cnt 0->1.
- x0 and unused operands:
  - id_ex_rd=0, id_rs1=0, memread=1 -> no stall.
  - id_ex_rd=7, id_rs2=7, id_use_rs2=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_write=1, id_ex_bubble=0.
- MUL/DIV, MD_LATENCY=4: ex_md_start held high ->
  - cycles 0-2: writes=0, ex_mem_bubble=1;
  - cycles 1-3: md_busy=1;
  - cycle 3: md_done=1 and writes=1;
  - stall_cnt +3.
- Reset mid-op: rst_n driven low in MD_BUSY cycle 2 -> all outputs 0 immediately; after release, state IDLE, stall_cnt=0, no md_done.
- Saturation: force stall_cnt to all-ones (CNT_W=4, count=15) and stall again -> stall_cnt stays 15.
